// File: rtl/ag2048_calc_pkg.sv
// Shared types and constants for the ag2048 keypad calculator.
// The optional divider is enabled by defining CALC_DIV_EN.
package ag2048_calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_ENTRY_B = 3'd1,
        ST_BUSY    = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    localparam logic [15:0] ERROR_DISPLAY = 16'hEEEE;

    // Wide enough that bits [19:16] flag a value that no longer fits in 16 bits.
    function automatic logic [19:0] appendDigit(input logic [15:0] value, input logic [3:0] digit);
        return {4'd0, value} * 20'd10 + {16'd0, digit};
    endfunction

endpackage

// File: rtl/ag2048_calc_divider.sv
// 16-cycle restoring divider for the calculator; one quotient bit per cycle.
// Only compiled into the design when CALC_DIV_EN is defined.
`ifdef CALC_DIV_EN
module ag2048_calc_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] dividend_i,
    input  logic [15:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] quotient_o
);

    logic        busy_q;
    logic [3:0]  count_q;
    logic [15:0] rem_q;
    logic [15:0] quot_q;
    logic [15:0] divisor_q;

    logic [16:0] remShift;
    logic [15:0] remSub;
    logic        unusedBorrow;
    logic        qBit;
    logic [15:0] remNext;
    logic [15:0] quotNext;

    // Dividend bits shift out of the quotient register into the remainder.
    assign remShift = {rem_q, quot_q[15]};
    assign {unusedBorrow, remSub} = remShift - {1'b0, divisor_q};
    assign qBit     = (remShift >= {1'b0, divisor_q});
    assign remNext  = qBit ? remSub : remShift[15:0];
    assign quotNext = {quot_q[14:0], qBit};

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (count_q == 4'd15);
    assign quotient_o = quotNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            count_q   <= 4'd0;
            rem_q     <= 16'd0;
            quot_q    <= 16'd0;
            divisor_q <= 16'd0;
        end else if (abort_i) begin
            busy_q  <= 1'b0;
            count_q <= 4'd0;
        end else if (start_i) begin
            busy_q    <= 1'b1;
            count_q   <= 4'd0;
            rem_q     <= 16'd0;
            quot_q    <= dividend_i;
            divisor_q <= divisor_i;
        end else if (busy_q) begin
            rem_q   <= remNext;
            quot_q  <= quotNext;
            count_q <= count_q + 4'd1;
            if (count_q == 4'd15) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/ag2048_calculator.sv
// Four-function 16-bit decimal-entry calculator core driven by keypad codes.
// Define CALC_DIV_EN to include the divide key, BUSY/ERROR states and the divider.
module ag2048_calculator
    import ag2048_calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    logic        strobePrev_q;
    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [1:0]  op_q;
    logic        bEntered_q;
    logic        ovf_q;

    logic        keyEvent;
    logic [3:0]  keyCode;
    logic        isDigit;
    logic        isOperator;
    logic        clearKey;
    logic [1:0]  keyOp;
    logic [19:0] aAppend;
    logic [19:0] bAppend;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [31:0] prod;
    logic [15:0] calcResult;
    logic        calcOvf;
    logic        busyFlag;
    logic [15:0] display;
    logic [7:0]  statusByte;
    logic        unusedInputs;

    assign unusedInputs = ^{uio_in, ui_in[6:5], bEntered_q};

    // Key code and strobe are synchronized together; the event is the synced rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 5'd0;
            sync2_q      <= 5'd0;
            strobePrev_q <= 1'b0;
        end else begin
            sync1_q      <= ui_in[4:0];
            sync2_q      <= sync1_q;
            strobePrev_q <= sync2_q[4];
        end
    end

    assign keyEvent = ena && sync2_q[4] && !strobePrev_q;
    assign keyCode  = sync2_q[3:0];
    assign isDigit  = (keyCode <= 4'd9);
    assign clearKey = keyEvent && (keyCode == KEY_CLR);
    assign keyOp    = 2'(keyCode - KEY_ADD);
`ifdef CALC_DIV_EN
    assign isOperator = keyCode inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV};
`else
    assign isOperator = keyCode inside {KEY_ADD, KEY_SUB, KEY_MUL};
`endif

    assign aAppend = appendDigit(a_q, keyCode);
    assign bAppend = appendDigit(b_q, keyCode);
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    assign diff    = {1'b0, a_q} - {1'b0, b_q};
    assign prod    = {16'd0, a_q} * {16'd0, b_q};

    always_comb begin
        calcResult = sum[15:0];
        calcOvf    = sum[16];
        case (op_q)
            OP_ADD: begin
                calcResult = sum[15:0];
                calcOvf    = sum[16];
            end
            OP_SUB: begin
                calcResult = diff[15:0];
                calcOvf    = diff[16];
            end
            OP_MUL: begin
                calcResult = prod[15:0];
                calcOvf    = |prod[31:16];
            end
            default: ;
        endcase
    end

`ifdef CALC_DIV_EN
    logic        divStart;
    logic        divBusy;
    logic        divDone;
    logic [15:0] divQuot;

    assign divStart = keyEvent && (state_q == ST_ENTRY_B) && (keyCode == KEY_EQ)
                      && (op_q == OP_DIV) && (b_q != 16'd0);

    ag2048_calc_divider u_divider (
        .clk        (clk),
        .rst        (rst),
        .start_i    (divStart),
        .abort_i    (clearKey),
        .dividend_i (a_q),
        .divisor_i  (b_q),
        .busy_o     (divBusy),
        .done_o     (divDone),
        .quotient_o (divQuot)
    );

    assign busyFlag = divBusy;
`else
    assign busyFlag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ENTRY_A;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            op_q       <= OP_ADD;
            bEntered_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (clearKey) begin
            state_q    <= ST_ENTRY_A;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            op_q       <= OP_ADD;
            bEntered_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_ENTRY_A, ST_RESULT: begin
                    if (keyEvent && isDigit) begin
                        if (state_q == ST_RESULT) begin
                            a_q     <= {12'd0, keyCode};
                            ovf_q   <= 1'b0;
                            state_q <= ST_ENTRY_A;
                        end else if (aAppend[19:16] != 4'd0) begin
                            ovf_q <= 1'b1;
                        end else begin
                            a_q <= aAppend[15:0];
                        end
                    end else if (keyEvent && isOperator) begin
                        op_q       <= keyOp;
                        b_q        <= 16'd0;
                        bEntered_q <= 1'b0;
                        state_q    <= ST_ENTRY_B;
                    end
                end
                ST_ENTRY_B: begin
                    if (keyEvent && isDigit) begin
                        if (bAppend[19:16] != 4'd0) begin
                            ovf_q <= 1'b1;
                        end else begin
                            b_q        <= bAppend[15:0];
                            bEntered_q <= 1'b1;
                        end
                    end else if (keyEvent && isOperator) begin
                        op_q <= keyOp;
                    end else if (keyEvent && (keyCode == KEY_EQ)) begin
                        ovf_q <= 1'b0;
                        if (op_q == OP_DIV) begin
`ifdef CALC_DIV_EN
                            state_q <= (b_q == 16'd0) ? ST_ERROR : ST_BUSY;
`endif
                        end else begin
                            a_q     <= calcResult;
                            ovf_q   <= calcOvf;
                            state_q <= ST_RESULT;
                        end
                    end
                end
                ST_BUSY: begin
`ifdef CALC_DIV_EN
                    if (divDone) begin
                        a_q     <= divQuot;
                        state_q <= ST_RESULT;
                    end
`endif
                end
                ST_ERROR: ;
                default: state_q <= ST_ENTRY_A;
            endcase
        end
    end

    always_comb begin
        display = a_q;
        if (state_q == ST_ENTRY_B) begin
            display = b_q;
        end else if (state_q == ST_ERROR) begin
            display = ERROR_DISPLAY;
        end
    end

    assign statusByte = {state_q == ST_ERROR, ovf_q, busyFlag, state_q, op_q};
    assign uo_out     = ui_in[7] ? statusByte : display[7:0];
    assign uio_out    = display[15:8];
    assign uio_oe     = 8'hFF;

endmodule

// File: tb/tb_ag2048_calculator.sv
// Self-checking bench for ag2048_calculator: an abstract calculator model checked every cycle
// plus hand-computed expectations; adapts to whether CALC_DIV_EN is defined.
module tb_ag2048_calculator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int compared = 0;
    int mismatched = 0;
    int busyCycles = 0;

    int mA = 0, mB = 0, mOp = 0, mState = 0, mOvf = 0, mBusyLeft = 0, mQuot = 0, cyc = 0;
    int dueQ[$];
    int codeQ[$];

    always #10 clk = ~clk;

    ag2048_calculator dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic modelClear();
        mA = 0; mB = 0; mOp = 0; mState = 0; mOvf = 0; mBusyLeft = 0;
    endtask

    // Calculator semantics at the key level; states use the numeric codes 0..4.
    task automatic modelKey(input int k);
        longint r;
        int cur;
        if (k <= 9) begin
            if (mState == 0 || mState == 1) begin
                cur = (mState == 0) ? mA : mB;
                if (cur * 10 + k > 65535) mOvf = 1;
                else if (mState == 0) mA = cur * 10 + k;
                else mB = cur * 10 + k;
            end else if (mState == 3) begin
                mA = k; mOvf = 0; mState = 0;
            end
`ifdef CALC_DIV_EN
        end else if (k >= 10 && k <= 13) begin
`else
        end else if (k >= 10 && k <= 12) begin
`endif
            if (mState == 0 || mState == 3) begin
                mOp = k - 10; mB = 0; mState = 1;
            end else if (mState == 1) begin
                mOp = k - 10;
            end
        end else if (k == 14 && mState == 1) begin
            mOvf = 0;
            if (mOp == 3) begin
                if (mB == 0) mState = 4;
                else begin mQuot = mA / mB; mBusyLeft = 16; mState = 2; end
            end else begin
                if (mOp == 0) r = longint'(mA) + mB;
                else if (mOp == 1) r = longint'(mA) - mB;
                else r = longint'(mA) * mB;
                mOvf = (r > 65535 || r < 0) ? 1 : 0;
                if (r < 0) r = r + 65536;
                mA = int'(r % 65536);
                mState = 3;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int k;
        bit haveKey;
        if (rst) begin
            modelClear();
            dueQ.delete();
            codeQ.delete();
            cyc = 0;
        end else begin
            cyc++;
            haveKey = 0;
            k = 0;
            if (dueQ.size() > 0 && dueQ[0] == cyc) begin
                void'(dueQ.pop_front());
                k = codeQ.pop_front();
                haveKey = 1;
            end
            if (haveKey && k == 15) begin
                modelClear();
            end else if (mState == 2) begin
                mBusyLeft--;
                if (mBusyLeft == 0) begin mA = mQuot; mState = 3; end
            end else if (haveKey) begin
                modelKey(k);
            end
        end
    end

    function automatic logic [15:0] modelDisplay();
        if (mState == 1) return 16'(mB);
        if (mState == 4) return 16'hEEEE;
        return 16'(mA);
    endfunction

    function automatic logic [7:0] modelStatus();
        logic [7:0] s;
        s = {mState == 4, mOvf != 0, mState == 2, 3'(mState), 2'(mOp)};
        return s;
    endfunction

    always @(negedge clk) begin
        logic [15:0] d;
        logic [7:0] expLow;
        d = modelDisplay();
        expLow = ui_in[7] ? modelStatus() : d[7:0];
        compared++;
        if (uo_out !== expLow) begin
            mismatched++;
            $display("[TB] FAIL uo_out cycle %0d: got %h expected %h", cyc, uo_out, expLow);
        end
        compared++;
        if (uio_out !== d[15:8]) begin
            mismatched++;
            $display("[TB] FAIL uio_out cycle %0d: got %h expected %h", cyc, uio_out, d[15:8]);
        end
        compared++;
        if (uio_oe !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL uio_oe cycle %0d: got %h expected ff", cyc, uio_oe);
        end
        if (ui_in[7] && uo_out[5]) busyCycles++;
    end

    task automatic applyStimulus(input logic [3:0] code, input int hold, input logic en);
        @(negedge clk);
        #2;
        ena = en;
        ui_in[4:0] = {1'b1, code};
        if (en) begin
            dueQ.push_back(cyc + 3);
            codeQ.push_back(int'(code));
        end
        repeat (hold) @(negedge clk);
        #2;
        ui_in[4] = 1'b0;
        repeat (4) @(negedge clk);
        ena = 1'b1;
    endtask

    task automatic applySequence(input logic [63:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(seq[4*i +: 4], 2, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expDisp, input logic [7:0] expStat);
        logic [15:0] d;
        logic [7:0] s;
        logic saved;
        @(negedge clk);
        #2;
        saved = ui_in[7];
        ui_in[7] = 1'b0;
        #1 d = {uio_out, uo_out};
        ui_in[7] = 1'b1;
        #1 s = uo_out;
        ui_in[7] = saved;
        compared++;
        if (d !== expDisp) begin
            mismatched++;
            $display("[TB] FAIL %s display: got %h expected %h", name, d, expDisp);
        end
        compared++;
        if (s !== expStat) begin
            mismatched++;
            $display("[TB] FAIL %s status: got %h expected %h", name, s, expStat);
        end
    endtask

    task automatic setView(input logic v);
        @(negedge clk);
        #2;
        ui_in[7] = v;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset", 16'h0000, 8'h00);
        #2 rst = 1'b0;

        applySequence(64'h12A34E, 6);
        checkOutput("add_result", 16'h002E, 8'h0C);
        applyStimulus(4'd7, 2, 1'b1);
        checkOutput("digit_after_result", 16'h0007, 8'h00);

        applySequence(64'hF300C300E, 9);
        checkOutput("mul_ovf", 16'h5F90, 8'h4E);
        applySequence(64'h3B5E, 4);
        checkOutput("sub_borrow", 16'hFFFE, 8'h4D);

        applyStimulus(4'hF, 2, 1'b1);
`ifdef CALC_DIV_EN
        setView(1'b1);
        busyCycles = 0;
        applySequence(64'h100D7E, 6);
        repeat (30) @(negedge clk);
        compared++;
        if (busyCycles != 16) begin
            mismatched++;
            $display("[TB] FAIL busy_length: got %0d expected 16", busyCycles);
        end
        setView(1'b0);
        checkOutput("div_result", 16'h000E, 8'h0F);

        applySequence(64'hF5D0E, 5);
        checkOutput("div_zero", 16'hEEEE, 8'h93);
        applyStimulus(4'd3, 2, 1'b1);
        checkOutput("error_ignores_digit", 16'hEEEE, 8'h93);
        applyStimulus(4'hF, 2, 1'b1);
        checkOutput("error_clear", 16'h0000, 8'h00);
`else
        applySequence(64'h100D7E, 6);
        checkOutput("div_disabled", 16'h03EF, 8'h00);
        applySequence(64'hF5D0E, 5);
        checkOutput("div_key_ignored", 16'h0032, 8'h00);
        applyStimulus(4'd3, 2, 1'b1);
        checkOutput("digit_after_ignored", 16'h01F7, 8'h00);
        applyStimulus(4'hF, 2, 1'b1);
        checkOutput("clear", 16'h0000, 8'h00);
`endif

        applySequence(64'h65536, 5);
        checkOutput("digit_ovf", 16'h1999, 8'h40);

        applySequence(64'hF1D2E, 5);
`ifdef CALC_DIV_EN
        applyStimulus(4'hF, 2, 1'b1);
        repeat (25) @(negedge clk);
        checkOutput("clear_during_busy", 16'h0000, 8'h00);
`else
        checkOutput("div_disabled_2", 16'h000C, 8'h00);
        applyStimulus(4'hF, 2, 1'b1);
        checkOutput("clear_2", 16'h0000, 8'h00);
`endif

        applyStimulus(4'd9, 2, 1'b0);
        checkOutput("ena_low", 16'h0000, 8'h00);
        applyStimulus(4'd8, 8, 1'b1);
        checkOutput("held_strobe", 16'h0008, 8'h00);

`ifdef CALC_DIV_EN
        applySequence(64'hF9D3E, 5);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_mid_div", 16'h0000, 8'h00);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("after_reset_div", 16'h0000, 8'h00);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ag2048_calculator.md
# ag2048_calculator

Four-function 16-bit unsigned decimal-entry calculator core for a Tiny-Tapeout-style tile. Takes keypad codes on a dedicated input byte, runs a small entry/compute state machine and drives a 16-bit display value (or a status byte) on the output pins. It sits directly under the tile top wrapper, which maps the pins 1:1 and inverts the pad reset into `rst`.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  tile enable; when low, key events are ignored and state holds.
- `ui_in`  in  8  [3:0] key code, [4] key strobe, [6:5] unused, [7] view select (1 = status).
- `uio_in`  in  8  unused, ignored.
- `uo_out`  out  8  view 0: display[7:0]; view 1: status byte.
- `uio_out`  out  8  display[15:8], regardless of view.
- `uio_oe`  out  8  constant 8'hFF.

## Operation
- Key codes: 0-9 digit; A add, B sub, C mul, D div, E equals, F clear. Codes A-D are operators.
- `ui_in[4:0]` passes through a 2-flop synchronizer. A key event is a 0→1 transition of the synced strobe while `ena`=1.
- Registers: `a`[15:0], `b`[15:0], `op`[1:0] (0 add, 1 sub, 2 mul, 3 div), `b_entered`, `ovf`.
- States: ENTRY_A=0, ENTRY_B=1, BUSY=2, RESULT=3, ERROR=4.
- Digit d:
  - ENTRY_A: `a`=a*10+d.
  - ENTRY_B: `b`=b*10+d, set `b_entered`.
  - RESULT: `a`=d, clear `ovf`, go to ENTRY_A.
  - If a*10+d > 65535, the digit is ignored and `ovf` is set.
- Operator:
  - ENTRY_A or RESULT: latch `op`, set `b`=0, clear `b_entered`, go to ENTRY_B.
  - ENTRY_B: replace `op` only (no chaining).
- Equals (ENTRY_B only; ignored elsewhere): clear `ovf`, then:
  - add: a+b, `ovf` on carry-out.
  - sub: a−b mod 2^16, `ovf` on borrow.
  - mul: low 16 bits of the product, `ovf` if the high 16 bits ≠ 0.
  - div with b=0: go to ERROR.
  - div with b≠0: go to BUSY.
  - Non-div results load `a` and go to RESULT.
- BUSY: restoring divider, one quotient bit per cycle for 16 cycles; then `a`=quotient, go to RESULT. Remainder is discarded.
- Clear (any state, including BUSY/ERROR): all registers zero, state ENTRY_A.
- In BUSY and ERROR, all keys except clear are ignored.
- Display value:
  - ENTRY_B: `b`.
  - ERROR: 16'hEEEE.
  - All other states: `a`.
- Status byte: {error, ovf, busy, state[2:0], op[1:0]}. error = state is ERROR; busy = state is BUSY.
- View select `ui_in[7]` is combinational to `uo_out` (not synchronized).

## Timing
- Reset values: `a`=`b`=0, `op`=0, state ENTRY_A, `ovf`=0, synchronizer flops 0, so `uo_out`=0 (view 0) and `uio_out`=0. `uio_oe` is 8'hFF at all times.
- Key latency: strobe sampled high at edge N → register/display update at edge N+2.
- Key codes must be stable from the strobe rising until two edges after it.
- Equals-to-result for add/sub/mul: same update edge as the key event.
- Div: enters BUSY at edge N+2; `a` updated and state RESULT at edge N+18. Busy status bit is high for exactly 16 cycles.
- A strobe held high produces one event. Keys arriving during BUSY are dropped, not queued.
- Reset asserted mid-division aborts immediately to reset values.

## Configuration
- `CALC_DIV_EN`
  - Defined: divider and BUSY state present; behaviour as above.
  - Undefined: key D is ignored, `op` never becomes 3, BUSY/ERROR are unreachable, and divider logic is absent.

## Structure
- Package `ag2048_calc_pkg`:
  - state enum and op encoding;
  - key-code constants (KEY_ADD..KEY_CLR);
  - ERROR display constant 16'hEEEE.
- Sub-module `ag2048_calc_divider`:
  - 16-cycle restoring divider with start/busy/done;
  - instantiated only under `CALC_DIV_EN`.

## Test plan
- Reset with view 0: `uo_out`=0, `uio_out`=0, `uio_oe`=FF. View 1: status 0x00.
- Keys 1,2,A,3,4,E → display 0x002E, state RESULT, `ovf`=0. Then digit 7 → display 0x0007, state ENTRY_A.
- Keys 3,0,0,C,3,0,0,E → display 0x5F90, `ovf`=1. Keys 3,B,5,E → 0xFFFE, `ovf`=1.
- Keys 1,0,0,D,7,E → busy bit high for 16 cycles, then display 0x000E.
- Keys 5,D,0,E → status bit7=1, display 0xEEEE. Digit 3 is ignored there; F → display 0, status 0x00.
- Keys 6,5,5,3,6 → display 6553 (0x1999) with `ovf`=1. Second case: 1,D,2,E, then F during BUSY → display 0, no result written afterwards.
